vec_lane_sequencer: RTL and testbench
=====================================

Name: vec_lane_sequencer

Overview:
- Initiator for the vector ALU lane interface (vcsub, aluop, input a/b, vx, c7 -> out).
- Accepts one packed multi-lane vector command and feeds one lane per cycle into a single combinational vector ALU lane.
- Captures each lane result and returns the repacked result vector with a valid/ready handshake.
- Sits between the vector register read stage and vector writeback.

Parameters:
- LANES, 4, number of 32-bit elements per vector command (power of two, >=2).
- W, 32, element width; must equal the ALU lane operand width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  ALU opcode (000 pass A, 001 interpolate, 010 blend, others yield 0).
- cmd_vcsub  in  1  force pass-through of A on all lanes.
- cmd_vx  in  16  packed r12:r11 constants.
- cmd_c7  in  8  blend weight (0..100).
- cmd_a  in  LANES*W  operand A vector; lane i = bits [i*W +: W].
- cmd_b  in  LANES*W  operand B vector.
- cmd_mask  in  LANES  1 = lane active; 0 = lane passes A unchanged.
- alu_vcsub  out  1  to ALU.
- alu_op  out  3  to ALU.
- alu_a  out  W  to ALU.
- alu_b  out  W  to ALU.
- alu_vx  out  16  to ALU.
- alu_c7  out  8  to ALU.
- alu_out  in  W  combinational ALU result for the currently driven operands.
- res_valid  out  1  result vector available.
- res_ready  in  1  consumer accepts result.
- res_data  out  LANES*W  packed results, same lane order as cmd_a.
- res_divz  out  LANES  per-lane flag: lane needed divide by zero (op 001, B==0).

Behaviour:
- States: IDLE, ISSUE, HOLD.
- Reset: synchronous, takes priority over everything including mid-ISSUE/HOLD (command aborted, no result emitted). State=IDLE, lane counter=0, cmd_ready=1 after reset release, res_valid=0, res_data=0, res_divz=0. All alu_* outputs are 0.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready:
  - Register all cmd_* fields.
  - Clear res_data and res_divz.
  - Go to ISSUE with lane=0.
- ISSUE: cmd_ready=0. alu_* outputs are driven from registers for the current lane:
  - alu_a/alu_b = lane slice.
  - alu_op/alu_vx/alu_c7 = the registered command fields.
  - alu_vcsub = reg_vcsub OR NOT mask[lane].
- ISSUE lane capture, at the clock edge ending the cycle:
  - If active lane, op==001, vcsub=0 and B==0: store 0 into res_data lane and set res_divz[lane]=1. Also drive alu_b=1 that cycle so the ALU never sees a zero divisor.
  - Otherwise: store alu_out into res_data lane.
- lane increments each cycle. After lane LANES-1 is captured, go to HOLD.
- HOLD: res_valid=1; res_data/res_divz are stable. alu_* outputs return to 0. On res_ready go to IDLE; res_valid drops next cycle.
- res_ready while not HOLD: ignored.
- No overlap: a new command is accepted only in IDLE, at the earliest the cycle after the result handshake.
- Latency: command accepted at edge 0; lanes issued in cycles 1..LANES; res_valid=1 from cycle LANES+1. With res_ready held high, throughput is one command per LANES+2 cycles.
- Mask all zero: still takes LANES issue cycles; result = cmd_a.
- cmd_* changes after acceptance have no effect.
- Counter width: clog2(LANES); wrap is not used, exit is on lane==LANES-1.

Test Plan:
- Reset then idle -> cmd_ready=1, res_valid=0, alu_* all 0; assert rst_n=0 mid-ISSUE (lane 2) -> next cycle IDLE, res_valid stays 0.
- op=001, vx r12=50 r11=10, A lanes {5,10,0,20}, B all 10, mask=1111 -> res_data {30,50,10,90}, res_divz=0000, res_valid at cycle 5.
- op=010, c7=25, A all 100, B all 200 -> all lanes 125; c7=0 -> all lanes 100.
- op=001, B lanes {10,0,10,0}, A all 5, vx r12=50 r11=10 -> res_data {30,0,30,0}, res_divz=1010, alu_b never observed 0 in ISSUE.
- mask=0101, op=010, c7=50, A all 40, B all 80 -> lanes 0,2 = 60; lanes 1,3 = 40; alu_vcsub=1 on lanes 1,3.
- res_ready held low 10 cycles in HOLD with cmd_valid=1 -> res_data stable, cmd_ready=0; raise res_ready -> IDLE, new command accepted the following cycle.

Source files
------------

// File: rtl/vec_lane_sequencer.sv
// Vector lane sequencer: takes one packed LANES-wide command, walks it through an external
// combinational ALU lane one element per cycle, and hands back the repacked result vector.
module vec_lane_sequencer #(
    parameter int LANES = 4,
    parameter int W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic               cmd_vcsub,
    input  logic [15:0]        cmd_vx,
    input  logic [7:0]         cmd_c7,
    input  logic [LANES*W-1:0] cmd_a,
    input  logic [LANES*W-1:0] cmd_b,
    input  logic [LANES-1:0]   cmd_mask,
    output logic               alu_vcsub,
    output logic [2:0]         alu_op,
    output logic [W-1:0]       alu_a,
    output logic [W-1:0]       alu_b,
    output logic [15:0]        alu_vx,
    output logic [7:0]         alu_c7,
    input  logic [W-1:0]       alu_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [LANES*W-1:0] res_data,
    output logic [LANES-1:0]   res_divz,
    output logic [1:0]         dbg_state
);

    localparam int LW = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LW-1:0]      lane_q, lane_d;
    logic [2:0]         op_q;
    logic               vcsub_q;
    logic [15:0]        vx_q;
    logic [7:0]         c7_q;
    logic [LANES*W-1:0] a_q, b_q;
    logic [LANES-1:0]   mask_q;
    logic [LANES*W-1:0] res_data_q;
    logic [LANES-1:0]   res_divz_q;

    logic               accept, capture, last_lane, lane_active, lane_divz;
    logic [W-1:0]       lane_a, lane_b;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // ready never depends on valid, and the offering side holds its payload until the transfer.
    assign lane_a      = a_q[int'(lane_q)*W +: W];
    assign lane_b      = b_q[int'(lane_q)*W +: W];
    assign lane_active = mask_q[lane_q];
    assign last_lane   = (lane_q == LW'(LANES - 1));
    // A zero divisor on an interpolating lane is resolved here, so the ALU is fed 1 instead.
    assign lane_divz   = lane_active && !vcsub_q && (op_q == 3'b001) && (lane_b == '0);

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        accept    = 1'b0;
        capture   = 1'b0;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        alu_vcsub = 1'b0;
        alu_op    = 3'b000;
        alu_a     = '0;
        alu_b     = '0;
        alu_vx    = 16'h0000;
        alu_c7    = 8'h00;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    lane_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                capture   = 1'b1;
                alu_vcsub = vcsub_q | ~lane_active;
                alu_op    = op_q;
                alu_a     = lane_a;
                alu_b     = lane_divz ? W'(1) : lane_b;
                alu_vx    = vx_q;
                alu_c7    = c7_q;
                lane_d    = lane_q + 1'b1;
                if (last_lane) begin
                    lane_d  = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            op_q       <= 3'b000;
            vcsub_q    <= 1'b0;
            vx_q       <= 16'h0000;
            c7_q       <= 8'h00;
            a_q        <= '0;
            b_q        <= '0;
            mask_q     <= '0;
            res_data_q <= '0;
            res_divz_q <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            if (accept) begin
                op_q       <= cmd_op;
                vcsub_q    <= cmd_vcsub;
                vx_q       <= cmd_vx;
                c7_q       <= cmd_c7;
                a_q        <= cmd_a;
                b_q        <= cmd_b;
                mask_q     <= cmd_mask;
                res_data_q <= '0;
                res_divz_q <= '0;
            end
            if (capture) begin
                res_data_q[int'(lane_q)*W +: W] <= lane_divz ? '0 : alu_out;
                res_divz_q[lane_q]              <= lane_divz;
            end
        end
    end

    assign res_data  = res_data_q;
    assign res_divz  = res_divz_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Bench for vec_lane_sequencer: models the external ALU lane, runs directed and random
// commands, and checks every result vector against a per-lane reference.
module tb_vec_lane_sequencer;

    localparam int LANES = 4;
    localparam int W     = 32;
    localparam int DW    = LANES * W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [2:0]      cmd_op = '0;
    logic            cmd_vcsub = 1'b0;
    logic [15:0]     cmd_vx = '0;
    logic [7:0]      cmd_c7 = '0;
    logic [DW-1:0]   cmd_a = '0;
    logic [DW-1:0]   cmd_b = '0;
    logic [LANES-1:0] cmd_mask = '0;
    logic            alu_vcsub;
    logic [2:0]      alu_op;
    logic [W-1:0]    alu_a, alu_b, alu_out;
    logic [15:0]     alu_vx;
    logic [7:0]      alu_c7;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [DW-1:0]   res_data;
    logic [LANES-1:0] res_divz;
    logic [1:0]      dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic mon_en = 1'b0;

    logic [DW-1:0]    exp_q[$];
    logic [LANES-1:0] exp_divz_q[$];
    logic [LANES-1:0] exp_vcs_q[$];
    logic             vcs_seen[$];

    vec_lane_sequencer #(.LANES(LANES), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_vcsub(cmd_vcsub),
        .cmd_vx(cmd_vx), .cmd_c7(cmd_c7), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_mask(cmd_mask),
        .alu_vcsub(alu_vcsub), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_vx(alu_vx), .alu_c7(alu_c7), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_divz(res_divz), .dbg_state(dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog");
    end

    // The ALU lane: interpolate r11 + a*(r12-r11)/b, blend (a*(100-c7)+b*c7)/100.
    function automatic logic [W-1:0] alu_fn(input logic vcsub, input logic [2:0] op,
                                            input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [15:0] vx, input logic [7:0] c7);
        logic [W-1:0] r11, r12, wt;
        r11 = W'(vx[7:0]);
        r12 = W'(vx[15:8]);
        wt  = W'(c7);
        if (vcsub) return a;
        case (op)
            3'b000:  return a;
            3'b001:  return (b == '0) ? 32'hDEAD_BEEF : r11 + (a * (r12 - r11)) / b;
            3'b010:  return (a * (W'(100) - wt) + b * wt) / W'(100);
            default: return '0;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_vcsub, alu_op, alu_a, alu_b, alu_vx, alu_c7);

    // Reference: each lane's result straight from the command rules.
    task automatic ref_model(input logic [2:0] op, input logic vcsub, input logic [15:0] vx,
                             input logic [7:0] c7, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [LANES-1:0] mask, output logic [DW-1:0] d,
                             output logic [LANES-1:0] z, output logic [LANES-1:0] vcs);
        logic [W-1:0] ai, bi;
        logic act;
        for (int i = 0; i < LANES; i++) begin
            ai = a[i*W +: W];
            bi = b[i*W +: W];
            act = mask[i] && !vcsub;
            vcs[i] = !act;
            if (act && op == 3'b001 && bi == '0) begin
                d[i*W +: W] = '0;
                z[i] = 1'b1;
            end else begin
                d[i*W +: W] = alu_fn(!act, op, ai, bi, vx, c7);
                z[i] = 1'b0;
            end
        end
    endtask

    function automatic logic [DW-1:0] rand_vec(input int maxv);
        logic [DW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*W +: W] = W'($urandom_range(maxv, 0));
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_cmd();
        cmd_op    = 3'($urandom);
        cmd_vcsub = 1'($urandom);
        cmd_vx    = 16'($urandom);
        cmd_c7    = 8'($urandom);
        cmd_a     = rand_vec(100000);
        cmd_b     = rand_vec(100000);
        cmd_mask  = LANES'($urandom);
    endtask

    // Driver: present one command, let it be accepted, then disturb the inputs.
    task automatic send(input logic [2:0] op, input logic vcsub, input logic [15:0] vx,
                        input logic [7:0] c7, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [LANES-1:0] mask);
        logic [DW-1:0] d;
        logic [LANES-1:0] z, v;
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            step();
            guard++;
        end
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_vcsub = vcsub; cmd_vx = vx; cmd_c7 = c7;
        cmd_a = a; cmd_b = b; cmd_mask = mask;
        ref_model(op, vcsub, vx, c7, a, b, mask, d, z, v);
        exp_q.push_back(d);
        exp_divz_q.push_back(z);
        exp_vcs_q.push_back(v);
        step();
        vcs_seen.delete();
        cmd_valid = 1'b0;
        scramble_cmd();
        check("cmd_ready_issue", cmd_ready, 0);
        check("res_valid_issue", res_valid, 0);
    endtask

    // Scoreboard side: wait for the result, compare, optionally stall, then hand it off.
    task automatic wait_result(input int hold, input logic [DW-1:0] cdata,
                               input logic [LANES-1:0] cdivz, input logic use_c);
        logic [DW-1:0] d;
        logic [LANES-1:0] z, v;
        int cyc;
        cyc = 1;
        while (!res_valid && cyc < 40) begin
            step();
            cyc++;
        end
        check("res_latency", cyc, LANES + 1);
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: observed empty queue expected entry");
            d = '0; z = '0; v = '0;
        end else begin
            d = exp_q.pop_front();
            z = exp_divz_q.pop_front();
            v = exp_vcs_q.pop_front();
        end
        check("res_data", res_data, d);
        check("res_divz", res_divz, z);
        if (use_c) begin
            check("res_data_const", res_data, cdata);
            check("res_divz_const", res_divz, cdivz);
        end
        check("issue_cycles", vcs_seen.size(), LANES);
        for (int i = 0; i < LANES && i < vcs_seen.size(); i++)
            check($sformatf("alu_vcsub_lane%0d", i), vcs_seen[i], v[i]);
        for (int k = 0; k < hold; k++) begin
            cmd_valid = 1'b1;
            scramble_cmd();
            res_ready = 1'b0;
            step();
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, d);
            check("hold_divz", res_divz, z);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_alu_a", alu_a, 0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("res_valid_drop", res_valid, 0);
        check("cmd_ready_back", cmd_ready, 1);
    endtask

    // Monitor: log alu_vcsub for each issued lane and watch for a zero divisor.
    always @(posedge clk) begin
        #2;
        if (mon_en && rst_n && !cmd_ready && !res_valid) begin
            vcs_seen.push_back(alu_vcsub);
            if (!alu_vcsub && alu_op == 3'b001) begin
                n_vec++;
                assert (alu_b !== '0) else begin
                    n_err++;
                    $error("FAIL alu_b_nonzero: observed %0h expected nonzero", alu_b);
                end
            end
        end
    end

    initial begin
        // Reset and idle outputs.
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        mon_en = 1'b1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_divz", res_divz, 0);
        check("rst_alu_bus", {alu_vcsub, alu_op, alu_a, alu_b, alu_vx, alu_c7}, 0);

        // Interpolate.
        send(3'b001, 1'b0, {8'd50, 8'd10}, 8'd0, {32'd20, 32'd0, 32'd10, 32'd5},
             {4{32'd10}}, 4'b1111);
        wait_result(0, {32'd90, 32'd10, 32'd50, 32'd30}, 4'b0000, 1'b1);

        // Blend at c7=25 and c7=0.
        send(3'b010, 1'b0, 16'h0, 8'd25, {4{32'd100}}, {4{32'd200}}, 4'b1111);
        wait_result(0, {4{32'd125}}, 4'b0000, 1'b1);
        send(3'b010, 1'b0, 16'h0, 8'd0, {4{32'd100}}, {4{32'd200}}, 4'b1111);
        wait_result(0, {4{32'd100}}, 4'b0000, 1'b1);

        // Divide by zero on lanes 1 and 3.
        send(3'b001, 1'b0, {8'd50, 8'd10}, 8'd0, {4{32'd5}},
             {32'd0, 32'd10, 32'd0, 32'd10}, 4'b1111);
        wait_result(0, {32'd0, 32'd30, 32'd0, 32'd30}, 4'b1010, 1'b1);

        // Partial mask.
        send(3'b010, 1'b0, 16'h0, 8'd50, {4{32'd40}}, {4{32'd80}}, 4'b0101);
        wait_result(0, {32'd40, 32'd60, 32'd40, 32'd60}, 4'b0000, 1'b1);

        // Long stall in HOLD with a command waiting, then back-to-back acceptance.
        send(3'b010, 1'b0, 16'h0, 8'd50, {4{32'd10}}, {4{32'd30}}, 4'b1111);
        wait_result(10, {4{32'd20}}, 4'b0000, 1'b1);
        send(3'b000, 1'b0, 16'h0, 8'd0, {32'd4, 32'd3, 32'd2, 32'd1}, '0, 4'b1111);
        wait_result(0, {32'd4, 32'd3, 32'd2, 32'd1}, 4'b0000, 1'b1);

        // All lanes masked: result equals A.
        send(3'b001, 1'b0, {8'd50, 8'd10}, 8'd0, {32'd7, 32'd8, 32'd9, 32'd11}, '0, 4'b0000);
        wait_result(0, {32'd7, 32'd8, 32'd9, 32'd11}, 4'b0000, 1'b1);

        // Reset in the middle of ISSUE (lane 2 on the ALU) aborts the command.
        send(3'b010, 1'b0, 16'h0, 8'd10, {4{32'd50}}, {4{32'd60}}, 4'b1111);
        step();
        step();
        check("abort_alu_a_lane2", alu_a, 50);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        void'(exp_divz_q.pop_back());
        void'(exp_vcs_q.pop_back());
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_alu_bus", {alu_vcsub, alu_op, alu_a, alu_b, alu_vx, alu_c7}, 0);
        for (int k = 0; k < 4; k++) begin
            check("abort_res_valid", res_valid, 0);
            step();
        end

        // Randomized commands.
        for (int n = 0; n < 25; n++) begin
            send(3'($urandom_range(3, 0) == 0 ? $urandom_range(7, 3) : $urandom_range(2, 0)),
                 1'($urandom_range(7, 0) == 0), 16'($urandom), 8'($urandom_range(100, 0)),
                 rand_vec(1000), rand_vec((n % 3 == 0) ? 2 : 500), LANES'($urandom));
            wait_result($urandom_range(3, 0), '0, '0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
